// File: rtl/psram_qpi_model_pkg.sv
// Shared command codes and FSM state type for the PSRAM QPI device model.
package psram_pkg;

    localparam logic [7:0] CMD_QREAD  = 8'hEB;
    localparam logic [7:0] CMD_QWRITE = 8'h38;
    localparam logic [7:0] CMD_QPI_EN = 8'h35;
    localparam logic [7:0] CMD_QPI_EX = 8'hF5;

    typedef enum logic [2:0] {
        IDLE,
        CMD,
        ADDR,
        DUMMY,
        RDATA,
        WDATA,
        IGNORE
    } psram_state_t;

endpackage

// File: rtl/psram_qpi_model_if.sv
// Serial PSRAM bus as seen between the controller (master) and the device model (slave).
interface psram_qpi_model_if;

    logic       sck;
    logic       ce_n;
    logic [3:0] dio_in;
    logic [3:0] dio_out;
    logic [3:0] dio_oe;
    logic       qpi_mode;
    logic       cmd_err;

    modport master (
        output sck, ce_n, dio_in,
        input  dio_out, dio_oe, qpi_mode, cmd_err
    );

    modport slave (
        input  sck, ce_n, dio_in,
        output dio_out, dio_oe, qpi_mode, cmd_err
    );

endinterface

// File: rtl/psram_qpi_model_edge_sync.sv
// Brings sck, ce_n and dio_in into the system clock domain and turns the
// synchronised sck/ce_n levels into single-cycle event pulses.
module psram_edge_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       sck,
    input  logic       ce_n,
    input  logic [3:0] dio_in,
    output logic       sck_rise,
    output logic       sck_fall,
    output logic       cs_start,
    output logic       cs_end,
    output logic [3:0] dio_sync
);

    logic [SYNC_STAGES-1:0] sck_sync_reg;
    logic [SYNC_STAGES-1:0] ce_sync_reg;
    logic                   sck_prev_reg;
    logic                   ce_prev_reg;
    logic                   sck_s;
    logic                   ce_s;

    // ce_n resets to "low" so a transfer interrupted by reset is only picked up
    // again after ce_n has been seen high and then low.
    always_ff @(posedge clock) begin
        if (reset) begin
            sck_sync_reg <= '0;
            ce_sync_reg  <= '0;
            sck_prev_reg <= 1'b0;
            ce_prev_reg  <= 1'b0;
        end else begin
            sck_sync_reg <= {sck_sync_reg[SYNC_STAGES-2:0], sck};
            ce_sync_reg  <= {ce_sync_reg[SYNC_STAGES-2:0], ce_n};
            sck_prev_reg <= sck_sync_reg[SYNC_STAGES-1];
            ce_prev_reg  <= ce_sync_reg[SYNC_STAGES-1];
        end
    end

    // Data lines go through the same depth so they stay aligned with sck_rise.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_dio
            logic [SYNC_STAGES-1:0] line_reg;

            // Per-line synchroniser chain.
            always_ff @(posedge clock) begin
                if (reset) begin
                    line_reg <= '0;
                end else begin
                    line_reg <= {line_reg[SYNC_STAGES-2:0], dio_in[gi]};
                end
            end

            assign dio_sync[gi] = line_reg[SYNC_STAGES-1];
        end
    endgenerate

    assign sck_s    = sck_sync_reg[SYNC_STAGES-1];
    assign ce_s     = ce_sync_reg[SYNC_STAGES-1];
    assign cs_start =  ce_prev_reg & ~ce_s;
    assign cs_end   = ~ce_prev_reg &  ce_s;
    // Clock edges only count while the chip is selected.
    assign sck_rise =  sck_s & ~sck_prev_reg & ~ce_s;
    assign sck_fall = ~sck_s &  sck_prev_reg & ~ce_s;

endmodule

// File: rtl/psram_qpi_model.sv
// Synthesizable PSRAM device model: SPI/QPI command decode, quad address,
// quad read with dummy cycles and quad write into an internal byte memory.
module psram_qpi_model
    import psram_pkg::*;
#(
    parameter int MEM_BYTES   = 4096,
    parameter int ADDR_W      = 24,
    parameter int READ_DUMMY  = 6,
    parameter int SYNC_STAGES = 2
) (
    input  logic               clock,
    input  logic               reset,
    psram_qpi_model_if.slave   bus
);

    localparam int                IDX_W      = $clog2(MEM_BYTES);
    localparam int                CNT_W      = 8;
    localparam logic [ADDR_W-1:0] ADDR_MASK  = ADDR_W'(MEM_BYTES - 1);
    localparam logic [CNT_W-1:0]  ADDR_LAST  = CNT_W'(ADDR_W / 4 - 1);
    localparam logic [CNT_W-1:0]  DUMMY_CNT  = CNT_W'(READ_DUMMY);

    logic       sck_rise;
    logic       sck_fall;
    logic       cs_start;
    logic       cs_end;
    logic [3:0] dio_sync;

    psram_edge_sync #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_edge_sync (
        .clock    (clock),
        .reset    (reset),
        .sck      (bus.sck),
        .ce_n     (bus.ce_n),
        .dio_in   (bus.dio_in),
        .sck_rise (sck_rise),
        .sck_fall (sck_fall),
        .cs_start (cs_start),
        .cs_end   (cs_end),
        .dio_sync (dio_sync)
    );

    psram_state_t      state_reg,    state_next;
    logic [7:0]        cmd_reg,      cmd_next;
    logic [CNT_W-1:0]  cnt_reg,      cnt_next;
    logic [ADDR_W-1:0] addr_reg,     addr_next;
    logic [3:0]        nib_reg,      nib_next;
    logic              half_reg,     half_next;
    logic              qpi_reg,      qpi_next;
    logic              pend_reg,     pend_next;
    logic              pend_val_reg, pend_val_next;
    logic [3:0]        dio_out_reg,  dio_out_next;
    logic [3:0]        dio_oe_reg,   dio_oe_next;
    logic              cmd_err_reg,  cmd_err_next;
    logic              wr_en_reg,    wr_en_next;
    logic [IDX_W-1:0]  wr_addr_reg,  wr_addr_next;
    logic [7:0]        wr_data_reg,  wr_data_next;
    logic [7:0]        rd_data_reg;
    logic [7:0]        mem [MEM_BYTES];

    logic [7:0]        cmd_shift;
    logic [ADDR_W-1:0] addr_shift;
    logic [ADDR_W-1:0] addr_inc;
    logic [CNT_W-1:0]  cmd_last;

    // Byte memory: registered write one clock after a byte completes, and a
    // continuously registered read of the current address so the next byte is
    // ready well before the following sck fall.
    always_ff @(posedge clock) begin
        if (wr_en_reg) begin
            mem[wr_addr_reg] <= wr_data_reg;
        end
        rd_data_reg <= mem[addr_reg[IDX_W-1:0]];
    end

    // State and datapath registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg    <= IDLE;
            cmd_reg      <= '0;
            cnt_reg      <= '0;
            addr_reg     <= '0;
            nib_reg      <= '0;
            half_reg     <= 1'b0;
            qpi_reg      <= 1'b0;
            pend_reg     <= 1'b0;
            pend_val_reg <= 1'b0;
            dio_out_reg  <= '0;
            dio_oe_reg   <= '0;
            cmd_err_reg  <= 1'b0;
            wr_en_reg    <= 1'b0;
            wr_addr_reg  <= '0;
            wr_data_reg  <= '0;
        end else begin
            state_reg    <= state_next;
            cmd_reg      <= cmd_next;
            cnt_reg      <= cnt_next;
            addr_reg     <= addr_next;
            nib_reg      <= nib_next;
            half_reg     <= half_next;
            qpi_reg      <= qpi_next;
            pend_reg     <= pend_next;
            pend_val_reg <= pend_val_next;
            dio_out_reg  <= dio_out_next;
            dio_oe_reg   <= dio_oe_next;
            cmd_err_reg  <= cmd_err_next;
            wr_en_reg    <= wr_en_next;
            wr_addr_reg  <= wr_addr_next;
            wr_data_reg  <= wr_data_next;
        end
    end

    // Next-state and output decode; cs_end wins over any sck event.
    always_comb begin
        state_next    = state_reg;
        cmd_next      = cmd_reg;
        cnt_next      = cnt_reg;
        addr_next     = addr_reg;
        nib_next      = nib_reg;
        half_next     = half_reg;
        qpi_next      = qpi_reg;
        pend_next     = pend_reg;
        pend_val_next = pend_val_reg;
        dio_out_next  = dio_out_reg;
        dio_oe_next   = dio_oe_reg;
        cmd_err_next  = 1'b0;
        wr_en_next    = 1'b0;
        wr_addr_next  = wr_addr_reg;
        wr_data_next  = wr_data_reg;

        cmd_shift  = qpi_reg ? {cmd_reg[3:0], dio_sync} : {cmd_reg[6:0], dio_sync[0]};
        addr_shift = {addr_reg[ADDR_W-5:0], dio_sync};
        addr_inc   = (addr_reg + ADDR_W'(1)) & ADDR_MASK;
        cmd_last   = qpi_reg ? CNT_W'(1) : CNT_W'(7);

        if (cs_end) begin
            state_next   = IDLE;
            cmd_next     = '0;
            cnt_next     = '0;
            half_next    = 1'b0;
            dio_out_next = '0;
            dio_oe_next  = '0;
            pend_next    = 1'b0;
            if (pend_reg) begin
                qpi_next = pend_val_reg;
            end
        end else begin
            case (state_reg)
                IDLE: begin
                    if (cs_start) begin
                        state_next = CMD;
                        cnt_next   = '0;
                        cmd_next   = '0;
                    end
                end

                CMD: begin
                    if (sck_rise) begin
                        cmd_next = cmd_shift;
                        if (cnt_reg == cmd_last) begin
                            cnt_next = '0;
                            case (cmd_shift)
                                CMD_QREAD, CMD_QWRITE: state_next = ADDR;
                                CMD_QPI_EN: begin
                                    pend_next     = 1'b1;
                                    pend_val_next = 1'b1;
                                    state_next    = IGNORE;
                                end
                                CMD_QPI_EX: begin
                                    pend_next     = 1'b1;
                                    pend_val_next = 1'b0;
                                    state_next    = IGNORE;
                                end
                                default: begin
                                    cmd_err_next = 1'b1;
                                    state_next   = IGNORE;
                                end
                            endcase
                        end else begin
                            cnt_next = cnt_reg + CNT_W'(1);
                        end
                    end
                end

                ADDR: begin
                    if (sck_rise) begin
                        addr_next = addr_shift;
                        if (cnt_reg == ADDR_LAST) begin
                            cnt_next  = '0;
                            half_next = 1'b0;
                            addr_next = addr_shift & ADDR_MASK;
                            if (cmd_reg == CMD_QREAD) begin
                                state_next  = DUMMY;
                                dio_oe_next = 4'hF;
                            end else begin
                                state_next = WDATA;
                            end
                        end else begin
                            cnt_next = cnt_reg + CNT_W'(1);
                        end
                    end
                end

                DUMMY: begin
                    dio_oe_next = 4'hF;
                    if (sck_rise && (cnt_reg != DUMMY_CNT)) begin
                        cnt_next = cnt_reg + CNT_W'(1);
                    end else if (sck_fall && (cnt_reg == DUMMY_CNT)) begin
                        dio_out_next = rd_data_reg[7:4];
                        half_next    = 1'b1;
                        state_next   = RDATA;
                    end
                end

                RDATA: begin
                    dio_oe_next = 4'hF;
                    if (sck_fall) begin
                        if (half_reg) begin
                            dio_out_next = rd_data_reg[3:0];
                            half_next    = 1'b0;
                            addr_next    = addr_inc;
                        end else begin
                            dio_out_next = rd_data_reg[7:4];
                            half_next    = 1'b1;
                        end
                    end
                end

                WDATA: begin
                    if (sck_rise) begin
                        if (!half_reg) begin
                            nib_next  = dio_sync;
                            half_next = 1'b1;
                        end else begin
                            wr_en_next   = 1'b1;
                            wr_data_next = {nib_reg, dio_sync};
                            wr_addr_next = addr_reg[IDX_W-1:0];
                            addr_next    = addr_inc;
                            half_next    = 1'b0;
                        end
                    end
                end

                IGNORE: begin
                    dio_oe_next = '0;
                end

                default: begin
                    state_next = IDLE;
                end
            endcase
        end
    end

    assign bus.dio_out  = dio_out_reg;
    assign bus.dio_oe   = dio_oe_reg;
    assign bus.qpi_mode = qpi_reg;
    assign bus.cmd_err  = cmd_err_reg;

endmodule

// File: tb/tb_psram_qpi_model.sv
// Directed bench for psram_qpi_model: a bus-functional controller drives
// transactions, expected read nibbles go into a queue and a monitor on sck
// rising edges pops and compares them.
module tb_psram_qpi_model;
    import psram_pkg::*;

    localparam int MEM_BYTES   = 4096;
    localparam int ADDR_W      = 24;
    localparam int READ_DUMMY  = 6;
    localparam int SYNC_STAGES = 2;
    localparam int H           = 6;   // system clocks per sck half period

    logic clock = 1'b0;
    logic reset = 1'b1;

    always #5 clock = ~clock;

    psram_qpi_model_if bus();

    psram_qpi_model #(
        .MEM_BYTES   (MEM_BYTES),
        .ADDR_W      (ADDR_W),
        .READ_DUMMY  (READ_DUMMY),
        .SYNC_STAGES (SYNC_STAGES)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    logic [3:0] exp_q[$];
    logic [3:0] mon_exp;
    logic       sample_en  = 1'b0;
    int         n_cmp      = 0;
    int         n_bad      = 0;
    int         err_pulses = 0;
    int         oe_cycles  = 0;

    // Monitor: the controller samples read data on each sck rise of the data phase.
    always @(posedge bus.sck) begin
        if (sample_en) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_bad++;
                $display("FAIL rd_nibble: got oe=%h data=%h, no nibble expected", bus.dio_oe, bus.dio_out);
            end else begin
                mon_exp = exp_q.pop_front();
                if ({bus.dio_oe, bus.dio_out} !== {4'hF, mon_exp}) begin
                    n_bad++;
                    $display("FAIL rd_nibble: got oe=%h data=%h, expected oe=f data=%h",
                             bus.dio_oe, bus.dio_out, mon_exp);
                end
            end
        end
    end

    // Cycle-level counters for the error pulse width and any output enable.
    always @(negedge clock) begin
        if (bus.cmd_err === 1'b1) err_pulses++;
        if (bus.dio_oe !== 4'h0) oe_cycles++;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic pulse(input logic [3:0] d);
        bus.dio_in = d;
        wait_clk(H);
        bus.sck = 1'b1;
        wait_clk(H);
        bus.sck = 1'b0;
    endtask

    task automatic cs_low();
        bus.ce_n = 1'b0;
        wait_clk(H);
    endtask

    task automatic cs_high();
        wait_clk(H);
        bus.ce_n = 1'b1;
        wait_clk(2 * H);
    endtask

    task automatic send_cmd(input logic [7:0] c, input bit q);
        if (q) begin
            pulse(c[7:4]);
            pulse(c[3:0]);
        end else begin
            for (int i = 7; i >= 0; i--) pulse({3'b000, c[i]});
        end
    endtask

    task automatic send_addr(input logic [23:0] a, input int first, input int n);
        for (int i = first; i < first + n; i++) pulse(a[23 - 4*i -: 4]);
    endtask

    task automatic write_txn(input bit q, input logic [23:0] a, input logic [31:0] nibs, input int n);
        $display("txn write qpi=%0d addr=%h nibbles=%0d data=%h", q, a, n, nibs);
        cs_low();
        send_cmd(CMD_QWRITE, q);
        send_addr(a, 0, 6);
        for (int i = 0; i < n; i++) pulse(nibs[31 - 4*i -: 4]);
        cs_high();
    endtask

    task automatic read_txn(input bit q, input logic [23:0] a, input logic [31:0] bytes, input int nb);
        $display("txn read  qpi=%0d addr=%h bytes=%0d expect=%h", q, a, nb, bytes);
        for (int i = 0; i < 2 * nb; i++) exp_q.push_back(bytes[31 - 4*i -: 4]);
        cs_low();
        send_cmd(CMD_QREAD, q);
        send_addr(a, 0, 6);
        pulse(4'h0);
        check("oe_first_dummy", {28'd0, bus.dio_oe}, 32'hF);
        for (int i = 1; i < READ_DUMMY; i++) pulse(4'h0);
        sample_en = 1'b1;
        for (int i = 0; i < 2 * nb; i++) pulse(4'h0);
        sample_en = 1'b0;
        cs_high();
        check("rd_queue_drained", exp_q.size(), 0);
        check("oe_after_cs_end", {28'd0, bus.dio_oe}, 32'h0);
    endtask

    task automatic mode_txn(input logic [7:0] c, input bit q, input bit mode_before, input bit mode_after);
        $display("txn mode  qpi=%0d cmd=%h", q, c);
        cs_low();
        send_cmd(c, q);
        wait_clk(H);
        check("qpi_before_cs_end", {31'd0, bus.qpi_mode}, {31'd0, mode_before});
        cs_high();
        check("qpi_after_cs_end", {31'd0, bus.qpi_mode}, {31'd0, mode_after});
    endtask

    initial begin
        bus.sck    = 1'b0;
        bus.ce_n   = 1'b1;
        bus.dio_in = 4'h0;
        reset      = 1'b1;
        wait_clk(5);
        check("reset_outputs", {22'd0, bus.dio_out, bus.dio_oe, bus.qpi_mode, bus.cmd_err}, 32'h0);
        reset = 1'b0;
        wait_clk(2 * H);

        // 1: SPI write then SPI read of DEADBEEF
        write_txn(1'b0, 24'h000010, 32'hDEADBEEF, 8);
        read_txn(1'b0, 24'h000010, 32'hDEADBEEF, 4);

        // 2: enter QPI, QPI read, leave QPI
        mode_txn(CMD_QPI_EN, 1'b0, 1'b0, 1'b1);
        read_txn(1'b1, 24'h000010, 32'hDEADBEEF, 4);
        mode_txn(CMD_QPI_EX, 1'b1, 1'b1, 1'b0);

        // 3: wrap at the top of memory, and address aliasing above MEM_BYTES
        write_txn(1'b0, 24'(MEM_BYTES - 1), 32'h1122_0000, 4);
        read_txn(1'b0, 24'(MEM_BYTES - 1), 32'h1122_0000, 2);
        read_txn(1'b0, 24'h00F010, 32'hDE00_0000, 1);

        // 4: trailing odd nibble is discarded
        write_txn(1'b0, 24'h000020, 32'h5566_0000, 4);
        write_txn(1'b0, 24'h000020, 32'hABC0_0000, 3);
        read_txn(1'b0, 24'h000020, 32'hAB66_0000, 2);

        // 5: unsupported command
        check("no_err_so_far", err_pulses, 0);
        oe_cycles = 0;
        $display("txn bad   qpi=0 cmd=9f");
        cs_low();
        send_cmd(8'h9F, 1'b0);
        pulse(4'h3);
        pulse(4'hC);
        cs_high();
        check("cmd_err_width", err_pulses, 1);
        check("oe_quiet_on_err", oe_cycles, 0);
        read_txn(1'b0, 24'h000010, 32'hDE00_0000, 1);

        // 6: reset in the middle of a QPI write address
        mode_txn(CMD_QPI_EN, 1'b0, 1'b0, 1'b1);
        $display("txn write qpi=1 addr=000010 interrupted by reset");
        cs_low();
        send_cmd(CMD_QWRITE, 1'b1);
        send_addr(24'h000010, 0, 3);
        reset = 1'b1;
        wait_clk(2);
        check("outputs_in_reset", {22'd0, bus.dio_out, bus.dio_oe, bus.qpi_mode, bus.cmd_err}, 32'h0);
        wait_clk(2);
        reset = 1'b0;
        wait_clk(H);
        send_addr(24'h000010, 3, 3);
        pulse(4'h1);
        pulse(4'h2);
        pulse(4'h3);
        pulse(4'h4);
        cs_high();
        check("qpi_cleared_by_reset", {31'd0, bus.qpi_mode}, 32'h0);
        read_txn(1'b0, 24'h000010, 32'hDEADBEEF, 4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/psram_qpi_model.md
Name: psram_qpi_model

Overview:
- Synthesizable, single-clock successor to the PSRAM device model. It has its own internal byte memory, so there is no DPI dependency.
- `sck`/`ce_n` are oversampled in the system clock domain. Supports SPI and QPI command modes, a parametrised dummy-cycle count, memory size and synchroniser depth.
- Sits behind the SoC PSRAM controller in simulation and FPGA builds, replacing the behavioural model. Split tristate: top level owns the `dio` pads.

Parameters:
- MEM_BYTES, 4096: memory size in bytes; power of two.
- ADDR_W, 24: address bits received on the bus.
- READ_DUMMY, 6: sck rising edges between the last address nibble and the first read-data nibble.
- SYNC_STAGES, 2: synchroniser flops on `sck`, `ce_n` and `dio_in`; ≥2.

Ports:
- clock  input  1  system clock; must be ≥4x sck frequency.
- reset  input  1  synchronous, active-high.
- sck  input  1  serial clock from the controller.
- ce_n  input  1  chip enable, low active.
- dio_in  input  4  data lines in.
- dio_out  output  4  data lines out.
- dio_oe  output  4  per-line output enable; all bits equal.
- qpi_mode  output  1  1 = QPI command mode active.
- cmd_err  output  1  one-cycle pulse on an unsupported command.

Behaviour:
- Reset
  - `dio_out`=0, `dio_oe`=0, `qpi_mode`=0, `cmd_err`=0, state=IDLE, all counters 0.
  - Memory contents are not cleared.
  - Reset mid-transfer aborts with no memory write; the FSM stays IDLE until `ce_n` is seen high, then low again.
- Synchronisation and edge events (per clock, from synchronised signals)
  - `sck_rise`, `sck_fall`, `cs_start` (ce_n falls), `cs_end` (ce_n rises).
  - `dio_in` is sampled on the cycle `sck_rise` is flagged.
  - `cs_end` has priority over any simultaneous `sck` event.
  - `sck` events while `ce_n` is high are ignored.
- States: IDLE, CMD, ADDR, DUMMY, RDATA, WDATA, IGNORE.
- IDLE → CMD on `cs_start`.
- CMD
  - SPI: 8 rises, shifting `dio_in[0]` MSB first.
  - QPI: 2 rises, shifting a nibble high-first.
  - At completion: 0xEB or 0x38 → ADDR. 0x35 → set `qpi_mode`, 0xF5 → clear `qpi_mode`; for both, the mode change takes effect on `cs_end` and the FSM goes to IGNORE. Any other value → `cmd_err` pulse, IGNORE.
- ADDR
  - Always quad, ADDR_W/4 rises, MSB nibble first.
  - Effective address = addr mod MEM_BYTES.
  - 0xEB → DUMMY, 0x38 → WDATA.
- DUMMY
  - Reading the byte at the effective address is registered on entry.
  - `dio_oe`=4'hF during DUMMY and RDATA.
  - After READ_DUMMY rises, the next `sck_fall` drives the high nibble onto `dio_out` and the FSM enters RDATA.
- RDATA
  - Each `sck_fall` drives the next nibble: high nibble, then low nibble, then the next byte.
  - Address increments per byte and wraps MEM_BYTES-1 → 0.
  - The next byte is fetched early enough that no nibble is late at 4x oversampling.
- WDATA
  - Nibbles assemble high-first. Each completed byte is written at the current address on the clock after its second nibble; address increments with the same wrap.
  - A trailing odd nibble at `cs_end` is discarded.
- IGNORE: no bus activity, `dio_oe`=0.
- Any state: `cs_end` → IDLE, `dio_oe`=0 the next clock, counters cleared.
- `ce_n` rising mid-CMD or mid-ADDR: aborted, no side effects.

Decomposition:
- Package `psram_pkg`:
  - command constants `CMD_QREAD`=8'hEB, `CMD_QWRITE`=8'h38, `CMD_QPI_EN`=8'h35, `CMD_QPI_EX`=8'hF5;
  - `psram_state_t` enum.
- Sub-module `psram_edge_sync`: SYNC_STAGES synchroniser on `sck`/`ce_n`/`dio_in`, plus rise/fall/start/end pulse generation.
- Memory is an inferred byte array in the top module.

Test Plan:
1. SPI write 0x38, addr 0x000010, data nibbles DEADBEEF; then SPI read 0xEB at 0x000010 → after 6 dummy rises, `dio_out` nibbles D,E,A,D,B,E,E,F; `dio_oe`=F from the first dummy to `ce_n` high.
2. SPI 0x35, `ce_n` high → `qpi_mode`=1. QPI read of test 1's address (cmd in 2 rises) returns 0xDEADBEEF; then QPI 0xF5 → `qpi_mode`=0 after `cs_end`.
3. Write 0x11,0x22 at addr MEM_BYTES-1, then read 2 bytes at MEM_BYTES-1 → 0x11 then 0x22, the latter from addr 0 (wrap).
4. Write at 0x20 with 3 nibbles A,B,C, then read 2 bytes at 0x20 → 0xAB, old value at 0x21 unchanged.
5. Command 0x9F → `cmd_err` high exactly 1 clock; `dio_oe` stays 0; next transaction works normally.
6. Assert `reset` mid-ADDR of a write, then a full read → no memory change, `qpi_mode`=0, outputs at reset values during reset.
